afifo_wr_arb: RTL and testbench

AFIFO_WR_ARB -- requirements
Module: afifo_wr_arb

---
 rtl/afifo_pkg.sv | 16 +
 rtl/afifo_rr_pick.sv | 51 +++++
 rtl/afifo_wr_arb.sv | 152 +++++++++++++++
 tb/tb_afifo_wr_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared types and default constants for the FIFO write-side arbiter.
// Optional feature macro: AFIFO_ARB_LOCK_EN (burst lock, see afifo_wr_arb.sv).
package afifo_pkg;

   // Default values for the arbiter parameters.
   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MAX_BURST  = 8;

   // Arbiter FSM: IDLE arbitrates, GRANT streams beats from the owner.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage : afifo_pkg

// File: rtl/afifo_rr_pick.sv
// Combinational round-robin picker: returns the first valid requester
// strictly after rr_ptr, wrapping from NUM_REQ-1 back to 0.
module afifo_rr_pick
   import afifo_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   pick,
   output logic               any_valid
);

   // One extra bit so rr_ptr + 1 + offset never overflows before wrapping.
   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W:0]     start_raw;
   logic [IDX_W:0]     start;
   logic [NUM_REQ-1:0] rot;
   logic [IDX_W-1:0]   cand [NUM_REQ];

   // Search begins at the requester right after the last owner.
   assign start_raw = {1'b0, rr_ptr} + (IDX_W+1)'(1);
   assign start     = (start_raw >= N_W) ? (start_raw - N_W) : start_raw;

   // Rotate the valids so bit 0 of rot is the highest-priority requester.
   assign rot = NUM_REQ'({req_valid, req_valid} >> start);

   // Absolute requester index for each rotated position.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         assign sum      = start + (IDX_W+1)'(gi);
         assign cand[gi] = IDX_W'((sum >= N_W) ? (sum - N_W) : sum);
      end
   endgenerate

   // Priority encode: the lowest rotated position that is valid wins.
   always_comb begin
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            pick = cand[k];
         end
      end
   end

   assign any_valid = |req_valid;

endmodule : afifo_rr_pick

// File: rtl/afifo_wr_arb.sv
// Round-robin arbiter feeding N requesters into one async-FIFO write port.
// Beats pass through combinationally (zero latency) while a grant is held.
// Optional feature macro: AFIFO_ARB_LOCK_EN -- when defined, a grant holds
// for up to MAX_BURST consecutive beats; otherwise each beat releases.
module afifo_wr_arb
   import afifo_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST
) (
   input  logic                          wclk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
   output logic                          busy
);

   localparam int             IDX_W    = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);

   // Parameter sanity checks at elaboration.
   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("afifo_wr_arb: NUM_REQ must be in 2..16");
   end
   if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
      $error("afifo_wr_arb: MAX_BURST must be in 1..256");
   end

   arb_state_t        state_reg, state_next;
   logic [IDX_W-1:0]  gnt_id_reg, gnt_id_next;
   logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [IDX_W-1:0]  pick_idx;
   logic              any_valid;
   logic              owner_valid;
   logic              ready_en;
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

`ifdef AFIFO_ARB_LOCK_EN
   localparam int               CNT_W    = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
   logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
`endif

   // Split the flat data bus into one word per requester.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
         assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   afifo_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_reg),
      .pick      (pick_idx),
      .any_valid (any_valid)
   );

   assign owner_valid = req_valid[gnt_id_reg];

   // State register plus grant bookkeeping; reset aborts any grant at once.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_reg    <= IDLE;
         gnt_id_reg   <= '0;
         rr_ptr_reg   <= RR_RESET;
`ifdef AFIFO_ARB_LOCK_EN
         beat_cnt_reg <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         gnt_id_reg   <= gnt_id_next;
         rr_ptr_reg   <= rr_ptr_next;
`ifdef AFIFO_ARB_LOCK_EN
         beat_cnt_reg <= beat_cnt_next;
`endif
      end
   end

   // Next-state logic: arbitrate in IDLE, release on drop or end of burst.
   always_comb begin
      state_next  = state_reg;
      gnt_id_next = gnt_id_reg;
      rr_ptr_next = rr_ptr_reg;
`ifdef AFIFO_ARB_LOCK_EN
      beat_cnt_next = beat_cnt_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (any_valid) begin
               gnt_id_next = pick_idx;
               state_next  = GRANT;
`ifdef AFIFO_ARB_LOCK_EN
               beat_cnt_next = '0;
`endif
            end
         end
         GRANT: begin
            if (!owner_valid) begin
               // Owner went away: hand priority on past it.
               state_next  = IDLE;
               rr_ptr_next = gnt_id_reg;
`ifdef AFIFO_ARB_LOCK_EN
               beat_cnt_next = '0;
`endif
            end else if (!wfull) begin
               // A beat transfers this cycle.
`ifdef AFIFO_ARB_LOCK_EN
               if (beat_cnt_reg == CNT_LAST) begin
                  state_next    = IDLE;
                  rr_ptr_next   = gnt_id_reg;
                  beat_cnt_next = '0;
               end else begin
                  beat_cnt_next = beat_cnt_reg + CNT_W'(1);
               end
`else
               state_next  = IDLE;
               rr_ptr_next = gnt_id_reg;
`endif
            end
            // wfull with owner valid: stall, keep grant and count.
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs: forced inactive while reset is asserted.
   always_comb begin
      busy     = (state_reg == GRANT) && !wrst;
      ready_en = busy && !wfull;
      winc     = ready_en && owner_valid;
      wdata    = data_arr[gnt_id_reg];
      gnt_id   = gnt_id_reg;
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = ready_en && (gnt_id_reg == IDX_W'(gi));
      end
   endgenerate

endmodule : afifo_wr_arb

// File: tb/tb_afifo_wr_arb.sv
// Self-checking bench for afifo_wr_arb (default 4 requesters, 32-bit data).
// Expected beats are queued when stimulus is driven and checked on winc.
module tb_afifo_wr_arb;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            wclk = 1'b0;
   logic            wrst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            wfull = 1'b0;
   logic            winc;
   logic [DW-1:0]   wdata;
   logic [1:0]      gnt_id;
   logic            busy;

   typedef struct {
      int          id;
      logic [31:0] data;
   } beat_t;

   beat_t sb[$];
   beat_t mon_e;
   int    n_cmp = 0;
   int    n_bad = 0;
   int    rr_seq[5] = '{0, 1, 2, 3, 0};

   afifo_wr_arb #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .MAX_BURST  (8)
   ) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .gnt_id    (gnt_id),
      .busy      (busy)
   );

   always #5 wclk = ~wclk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] dval(input int i, input int t);
      return 32'hD000_0000 | (32'(t) << 16) | 32'(i);
   endfunction

   task automatic set_data(input int t);
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dval(i, t);
   endtask

   task automatic push_exp(input int id, input logic [31:0] d);
      beat_t e;
      e.id   = id;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic smp();
      @(negedge wclk);
   endtask

   task automatic nxt();
      @(posedge wclk);
      #1;
   endtask

   // Scoreboard: every write strobe must match the next queued beat.
   always @(negedge wclk) begin
      if (winc) begin
         check("winc_while_full", 64'(wfull), 64'd0);
         if (sb.size() == 0) begin
            check("beat_unexpected", 64'(winc), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("beat_id", 64'(gnt_id), 64'(mon_e.id));
            check("beat_data", 64'(wdata), 64'(mon_e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset held 3 cycles with every requester valid.
      wrst      = 1'b1;
      req_valid = 4'hF;
      set_data(1);
      for (int k = 0; k < 3; k++) begin
         smp();
         check("rst_winc", 64'(winc), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_ready", 64'(req_ready), 64'd0);
         check("rst_wdata", 64'(wdata), 64'(dval(0, 1)));
         nxt();
      end
      wrst = 1'b0;

`ifndef AFIFO_ARB_LOCK_EN
      // Round-robin: one beat per grant, one idle cycle between grants.
      for (int g = 0; g < 5; g++) push_exp(rr_seq[g], dval(rr_seq[g], 1));
      for (int k = 0; k < 10; k++) begin
         smp();
         check("rr_winc", 64'(winc), 64'(k % 2));
         check("rr_busy", 64'(busy), 64'(k % 2));
         if (k % 2 == 1) check("rr_gnt", 64'(gnt_id), 64'(rr_seq[k/2]));
         nxt();
      end
      req_valid = '0;
      smp();
      check("rr_drain", 64'(sb.size()), 64'd0);
      nxt();

      // Full stall: grant held with no transfer, then one beat.
      set_data(2);
      req_valid = 4'b0010;
      wfull     = 1'b1;
      push_exp(1, dval(1, 2));
      smp();
      check("stall_idle", 64'(busy), 64'd0);
      nxt();
      for (int k = 1; k <= 5; k++) begin
         smp();
         check("stall_winc", 64'(winc), 64'd0);
         check("stall_ready", 64'(req_ready), 64'd0);
         check("stall_busy", 64'(busy), 64'd1);
         check("stall_gnt", 64'(gnt_id), 64'd1);
         nxt();
      end
      wfull = 1'b0;
      smp();
      check("resume_winc", 64'(winc), 64'd1);
      check("resume_ready", 64'(req_ready), 64'b0010);
      nxt();
      req_valid = '0;
      smp();
      check("stall_drain", 64'(sb.size()), 64'd0);
      nxt();

      // Early drop by owner 3: release, then wrap to requester 0.
      set_data(3);
      req_valid = 4'b1000;
      push_exp(0, dval(0, 3));
      smp();
      check("drop_idle", 64'(busy), 64'd0);
      nxt();
      req_valid = 4'b0101;
      smp();
      check("drop_busy", 64'(busy), 64'd1);
      check("drop_gnt", 64'(gnt_id), 64'd3);
      check("drop_winc", 64'(winc), 64'd0);
      nxt();
      smp();
      check("drop_arb", 64'(busy), 64'd0);
      nxt();
      smp();
      check("drop_next_winc", 64'(winc), 64'd1);
      check("drop_next_gnt", 64'(gnt_id), 64'd0);
      nxt();
      req_valid = '0;
      smp();
      check("drop_drain", 64'(sb.size()), 64'd0);
      nxt();

      // Reset in the middle of a grant: no strobe, priority back to 0.
      set_data(4);
      req_valid = 4'b0110;
      push_exp(1, dval(1, 4));
      smp();
      nxt();
      smp();
      check("rstmid_beat", 64'(winc), 64'd1);
      nxt();
      smp();
      nxt();
      wrst = 1'b1;
      smp();
      check("rstmid_winc", 64'(winc), 64'd0);
      check("rstmid_busy", 64'(busy), 64'd0);
      nxt();
      wrst      = 1'b0;
      req_valid = 4'b0111;
      push_exp(0, dval(0, 4));
      smp();
      check("rstmid_idle", 64'(busy), 64'd0);
      check("rstmid_gnt_rst", 64'(gnt_id), 64'd0);
      nxt();
      smp();
      check("rstmid_next_winc", 64'(winc), 64'd1);
      check("rstmid_next_gnt", 64'(gnt_id), 64'd0);
      nxt();
      req_valid = '0;
      smp();
      check("rstmid_drain", 64'(sb.size()), 64'd0);
      nxt();
`else
      // First grant after reset goes to 0 and locks for 8 beats.
      for (int g = 0; g < 8; g++) push_exp(0, dval(0, 1));
      for (int k = 0; k < 10; k++) begin
         smp();
         check("lock_winc", 64'(winc), 64'((k >= 1) && (k <= 8)));
         if (k == 1) check("first_gnt", 64'(gnt_id), 64'd0);
         nxt();
         if (k == 8) req_valid = '0;
      end
      check("lock_drain", 64'(sb.size()), 64'd0);

      // Stall mid-burst: 3 beats, 5 full cycles, 5 more beats, release.
      set_data(5);
      req_valid = 4'b0010;
      for (int k = 0; k < 15; k++) begin
         logic exp_beat;
         exp_beat = (k >= 1 && k <= 3) || (k >= 9 && k <= 13);
         req_data[DW +: DW] = 32'hE000_0000 + 32'(k);
         wfull = (k >= 4) && (k <= 8);
         if (exp_beat) push_exp(1, 32'hE000_0000 + 32'(k));
         smp();
         check("lstall_winc", 64'(winc), 64'(exp_beat));
         if (wfull) begin
            check("lstall_ready", 64'(req_ready), 64'd0);
            check("lstall_gnt", 64'(gnt_id), 64'd1);
         end
         nxt();
         if (k == 13) req_valid = '0;
      end
      wfull = 1'b0;
`endif

      smp();
      check("final_drain", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_afifo_wr_arb
